// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD stopwatch with run/pause/adjust FSM and 7-segment decode
module stopwatch_counter #(
    parameter logic [6:0] SEG_OFF = 7'b1111111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] minutes_tens_cathode,
    output logic [6:0] minutes_ones_cathode,
    output logic [6:0] seconds_tens_cathode,
    output logic [6:0] seconds_ones_cathode,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running
);
    typedef enum logic [1:0] {RUN, PAUSE, ADJUST} state_t;
    state_t state, state_next;
    logic count, adj_sec, adj_min, sec_wrap;
    logic [3:0] so_inc, st_inc, mo_inc, mt_inc;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SEG_OFF;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            RUN:    state_next = adj ? ADJUST : pause_pulse ? PAUSE : RUN;
            PAUSE:  state_next = adj ? ADJUST : pause_pulse ? RUN : PAUSE;
            ADJUST: state_next = adj ? ADJUST : PAUSE;
            default: state_next = RUN;
        endcase
    end

    // Adjust increments wrap within their own field; only a running count carries into minutes
    assign count    = state == RUN && !adj && tick_1hz;
    assign adj_sec  = state == ADJUST && tick_2hz && sel;
    assign adj_min  = state == ADJUST && tick_2hz && !sel;
    assign sec_wrap = sec_tens == 4'd5 && sec_ones == 4'd9;
    assign so_inc   = sec_ones == 4'd9 ? 4'd0 : sec_ones + 4'd1;
    assign st_inc   = sec_ones != 4'd9 ? sec_tens : sec_tens == 4'd5 ? 4'd0 : sec_tens + 4'd1;
    assign mo_inc   = min_ones == 4'd9 ? 4'd0 : min_ones + 4'd1;
    assign mt_inc   = min_ones != 4'd9 ? min_tens : min_tens == 4'd9 ? 4'd0 : min_tens + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else begin
            state <= state_next;
            if (count || adj_sec) begin
                sec_tens <= st_inc;
                sec_ones <= so_inc;
            end
            if ((count && sec_wrap) || adj_min) begin
                min_tens <= mt_inc;
                min_ones <= mo_inc;
            end
        end
    end

    assign running              = state == RUN;
    assign minutes_tens_cathode = seg(min_tens);
    assign minutes_ones_cathode = seg(min_ones);
    assign seconds_tens_cathode = seg(sec_tens);
    assign seconds_ones_cathode = seg(sec_ones);
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed self-checking bench for stopwatch_counter
module tb_stopwatch_counter;
    logic clk = 0, rst = 1, tick_1hz = 0, tick_2hz = 0, pause_pulse = 0, adj = 0, sel = 0;
    logic [6:0] minutes_tens_cathode, minutes_ones_cathode, seconds_tens_cathode, seconds_ones_cathode;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic running;
    int n_checks = 0, n_fail = 0;
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    stopwatch_counter dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
        .minutes_tens_cathode(minutes_tens_cathode), .minutes_ones_cathode(minutes_ones_cathode),
        .seconds_tens_cathode(seconds_tens_cathode), .seconds_ones_cathode(seconds_ones_cathode),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One posedge with the given pulses; outputs are sampled at the following negedge
    task automatic cyc(input logic t1, input logic t2, input logic pp);
        @(negedge clk);
        tick_1hz = t1;
        tick_2hz = t2;
        pause_pulse = pp;
        @(negedge clk);
        tick_1hz = 0;
        tick_2hz = 0;
        pause_pulse = 0;
    endtask

    task automatic chk_time(input string tag, input int m, input int s);
        logic [15:0] e;
        e = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        check(tag, 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'(e));
    endtask

    task automatic chk_dark(input string tag);
        check(tag, 32'({minutes_tens_cathode, minutes_ones_cathode, seconds_tens_cathode, seconds_ones_cathode}),
              32'({4{7'h40}}));
    endtask

    initial begin
        rst = 1;
        cyc(0, 0, 0);
        cyc(1, 1, 1);
        chk_time("reset_digits", 0, 0);
        check("reset_running", 32'(running), 1);
        chk_dark("reset_cathodes");
        rst = 0;

        cyc(1, 0, 0);
        chk_time("first_tick", 0, 1);
        for (int i = 2; i <= 61; i++) begin
            cyc(1, 0, 0);
            check("sec_ones_cath", 32'(seconds_ones_cathode), 32'(seg_tab[(i % 60) % 10]));
            check("sec_tens_cath", 32'(seconds_tens_cathode), 32'(seg_tab[(i % 60) / 10]));
        end
        chk_time("count_61", 1, 1);
        check("count_61_cath", 32'(seconds_ones_cathode), 32'h79);
        check("count_61_run", 32'(running), 1);

        rst = 1;
        cyc(0, 0, 0);
        rst = 0;
        repeat (5) cyc(1, 0, 0);
        chk_time("at_0005", 0, 5);
        cyc(1, 0, 1);
        chk_time("tick_pause", 0, 6);
        check("tick_pause_run", 32'(running), 0);
        repeat (3) cyc(1, 0, 0);
        chk_time("paused_hold", 0, 6);
        cyc(0, 1, 0);
        chk_time("pause_2hz_ignored", 0, 6);

        adj = 1;
        sel = 1;
        cyc(0, 0, 0);
        check("adjust_run", 32'(running), 0);
        cyc(1, 0, 1);
        chk_time("adjust_ignores", 0, 6);
        check("adjust_ignores_pause", 32'(running), 0);
        repeat (52) cyc(0, 1, 0);
        chk_time("adj_to_58", 0, 58);
        repeat (3) cyc(0, 1, 0);
        chk_time("adj_sec_wrap", 0, 1);
        sel = 0;
        cyc(0, 0, 0);
        chk_time("sel_no_tick", 0, 1);
        repeat (2) cyc(0, 1, 0);
        chk_time("adj_min", 2, 1);
        for (int m = 3; m <= 99; m++) begin
            cyc(0, 1, 0);
            check("min_ones_cath", 32'(minutes_ones_cathode), 32'(seg_tab[m % 10]));
            check("min_tens_cath", 32'(minutes_tens_cathode), 32'(seg_tab[m / 10]));
        end
        chk_time("adj_99", 99, 1);
        cyc(0, 1, 0);
        chk_time("adj_min_wrap", 0, 1);
        repeat (99) cyc(0, 1, 0);
        sel = 1;
        repeat (58) cyc(0, 1, 0);
        chk_time("preload_9959", 99, 59);
        adj = 0;
        cyc(0, 0, 0);
        check("adj_exit_pause", 32'(running), 0);
        cyc(0, 0, 1);
        check("pause_to_run", 32'(running), 1);
        cyc(1, 0, 0);
        chk_time("wrap_9959", 0, 0);
        chk_dark("wrap_cathodes");

        repeat (10) cyc(1, 0, 0);
        chk_time("at_0010", 0, 10);
        adj = 1;
        cyc(1, 0, 0);
        chk_time("adj_drops_tick", 0, 10);
        check("adj_drops_tick_run", 32'(running), 0);
        adj = 0;
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk_time("2hz_in_pause", 0, 10);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        chk_time("2hz_in_run", 0, 10);
        check("2hz_in_run_run", 32'(running), 1);

        adj = 1;
        sel = 1;
        cyc(0, 0, 1);
        check("adj_over_pause", 32'(running), 0);
        cyc(0, 1, 0);
        chk_time("adj_over_pause_sec", 0, 11);
        sel = 0;
        repeat (45) cyc(0, 1, 0);
        sel = 1;
        repeat (19) cyc(0, 1, 0);
        chk_time("at_4530", 45, 30);
        rst = 1;
        cyc(1, 1, 1);
        chk_time("rst_in_adjust", 0, 0);
        check("rst_in_adjust_run", 32'(running), 1);
        chk_dark("rst_in_adjust_cath");
        rst = 0;
        adj = 0;
        cyc(1, 0, 0);
        chk_time("post_rst_tick", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
